bp_be_cache_req_arbiter: RTL and testbench

Round-robin arbiter that shares the single D$-to-LCE cache-service request port (request, metadata, completion) among `num_req_p` backend requesters, such as the D$ miss path and a page-table walker. It sits between the requesters and the LCE request interface. It holds exactly one request outstanding until the LCE signals completion, then returns a one-cycle completion pulse to the owning requester.

---
 rtl/bp_be_cache_req_arbiter.sv | 137 +++++++++++++
 tb/tb_bp_be_cache_req_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_cache_req_arbiter.sv
// Round-robin arbiter that shares the single D$-to-LCE cache-service request port among backend requesters.
// Exactly one request is outstanding at a time; completion returns to the owner as a one-cycle pulse.
module bp_be_cache_req_arbiter #(
  parameter int num_req_p    = 2,
  parameter int req_width_p  = 128,
  parameter int meta_width_p = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p*req_width_p-1:0]  req_i,
  input  logic [num_req_p-1:0]              req_v_i,
  output logic [num_req_p-1:0]              req_ready_o,
  input  logic [num_req_p*meta_width_p-1:0] req_metadata_i,
  input  logic [num_req_p-1:0]              req_metadata_v_i,
  output logic [num_req_p-1:0]              complete_o,
  output logic [req_width_p-1:0]            cache_req_o,
  output logic                              cache_req_v_o,
  input  logic                              cache_req_ready_i,
  output logic [meta_width_p-1:0]           cache_req_metadata_o,
  output logic                              cache_req_metadata_v_o,
  input  logic                              cache_req_complete_i,
  output logic                              busy_o,
  output logic [$clog2(num_req_p)-1:0]      grant_id_o
);
  localparam int gid_w = $clog2(num_req_p);
  typedef logic [gid_w-1:0] gid_t;
  localparam gid_t last_id = gid_t'(num_req_p - 1);

  // state  | meaning
  // S_IDLE | arbitrating; ready offered to the round-robin winner
  // S_SEND | request held valid toward the LCE until it is accepted
  // S_META | metadata pending; emitted for one cycle once captured
  // S_WAIT | waiting for the LCE to finish the outstanding request
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_META, S_WAIT} state_t;

  state_t                  state;
  gid_t                    last_grant;
  gid_t                    winner;
  logic                    win_v;
  logic                    meta_have;
  logic                    own_meta;
  logic [num_req_p-1:0]    grant_onehot;
  logic [req_width_p-1:0]  req_slot  [num_req_p];
  logic [meta_width_p-1:0] meta_slot [num_req_p];

  for (genvar i = 0; i < num_req_p; i++) begin : g_slot
    assign req_slot[i]  = req_i[i*req_width_p +: req_width_p];
    assign meta_slot[i] = req_metadata_i[i*meta_width_p +: meta_width_p];
  end

  // Scan upward from the slot after the last owner, wrapping at num_req_p.
  always_comb begin
    gid_t idx;
    idx    = last_grant;
    winner = last_grant;
    win_v  = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = (idx == last_id) ? '0 : idx + 1'b1;
      if (!win_v && req_v_i[idx]) begin
        win_v  = 1'b1;
        winner = idx;
      end
    end
  end

  // Ready is gated by reset so every output reads zero while reset is held.
  always_comb begin
    req_ready_o = '0;
    if (reset_n_i && state == S_IDLE && win_v) req_ready_o[winner] = 1'b1;
  end

  assign own_meta     = req_metadata_v_i[grant_id_o]
                      & ((state == S_SEND) | ((state == S_META) & ~cache_req_metadata_v_o));
  assign grant_onehot = {{(num_req_p-1){1'b0}}, 1'b1} << grant_id_o;
  assign busy_o       = (state != S_IDLE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state                  <= S_IDLE;
      last_grant             <= last_id;
      meta_have              <= 1'b0;
      grant_id_o             <= '0;
      cache_req_o            <= '0;
      cache_req_v_o          <= 1'b0;
      cache_req_metadata_o   <= '0;
      cache_req_metadata_v_o <= 1'b0;
      complete_o             <= '0;
    end else begin
      complete_o <= '0;
      // A later owner pulse before emission simply overwrites the held value.
      if (own_meta) begin
        cache_req_metadata_o <= meta_slot[grant_id_o];
        meta_have            <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (win_v) begin
            cache_req_o   <= req_slot[winner];
            cache_req_v_o <= 1'b1;
            grant_id_o    <= winner;
            last_grant    <= winner;
            meta_have     <= 1'b0;
            state         <= S_SEND;
          end
        end
        S_SEND: begin
          if (cache_req_ready_i) begin
            cache_req_v_o          <= 1'b0;
            cache_req_metadata_v_o <= meta_have | own_meta;
            state                  <= S_META;
          end
        end
        S_META: begin
          if (cache_req_metadata_v_o) begin
            cache_req_metadata_v_o <= 1'b0;
            if (cache_req_complete_i) begin
              complete_o <= grant_onehot;
              state      <= S_IDLE;
            end else begin
              state <= S_WAIT;
            end
          end else if (own_meta) begin
            cache_req_metadata_v_o <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cache_req_complete_i) begin
            complete_o <= grant_onehot;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_be_cache_req_arbiter.sv
// Self-checking bench for bp_be_cache_req_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin/metadata/completion model.
module tb_bp_be_cache_req_arbiter;
  localparam int N  = 2;
  localparam int RW = 128;
  localparam int MW = 8;

  logic            clk_i, reset_n_i;
  logic [N*RW-1:0] req_i;
  logic [N-1:0]    req_v_i, req_ready_o;
  logic [N*MW-1:0] req_metadata_i;
  logic [N-1:0]    req_metadata_v_i, complete_o;
  logic [RW-1:0]   cache_req_o;
  logic            cache_req_v_o, cache_req_ready_i;
  logic [MW-1:0]   cache_req_metadata_o;
  logic            cache_req_metadata_v_o, cache_req_complete_i, busy_o;
  logic [$clog2(N)-1:0] grant_id_o;

  int n_cmp, n_bad, m_last;

  bp_be_cache_req_arbiter #(.num_req_p(N), .req_width_p(RW), .meta_width_p(MW)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .req_i(req_i), .req_v_i(req_v_i),
    .req_ready_o(req_ready_o), .req_metadata_i(req_metadata_i), .req_metadata_v_i(req_metadata_v_i),
    .complete_o(complete_o), .cache_req_o(cache_req_o), .cache_req_v_o(cache_req_v_o),
    .cache_req_ready_i(cache_req_ready_i), .cache_req_metadata_o(cache_req_metadata_o),
    .cache_req_metadata_v_o(cache_req_metadata_v_o), .cache_req_complete_i(cache_req_complete_i),
    .busy_o(busy_o), .grant_id_o(grant_id_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    req_i = '0; req_v_i = '0; req_metadata_i = '0; req_metadata_v_i = '0;
    cache_req_ready_i = 1'b0; cache_req_complete_i = 1'b0;
  endtask

  // Called at edge+1; releases reset well before the next rising edge.
  task automatic do_reset();
    clear_inputs();
    reset_n_i = 1'b0;
    #2;
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    req_v_i = 2'b11;
    reset_n_i = 1'b0;
    step(); step();
    n_cmp++; if (req_ready_o !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b exp 00", req_ready_o); end
    n_cmp++; if (cache_req_v_o !== 1'b0 || cache_req_metadata_v_o !== 1'b0) begin n_bad++; $display("FAIL reset_valids: got %b%b exp 00", cache_req_v_o, cache_req_metadata_v_o); end
    n_cmp++; if (cache_req_o !== '0 || cache_req_metadata_o !== '0) begin n_bad++; $display("FAIL reset_data: got %h/%h exp 0", cache_req_o, cache_req_metadata_o); end
    n_cmp++; if (complete_o !== 2'b00 || busy_o !== 1'b0 || grant_id_o !== '0) begin n_bad++; $display("FAIL reset_misc: got cpl %b busy %b gid %0d exp 0", complete_o, busy_o, grant_id_o); end
    reset_n_i = 1'b1;
    #1;
    n_cmp++; if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL reset_first_prio: got %b exp 01", req_ready_o); end
    req_v_i = '0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    req_i[0 +: RW] = {16{8'hA5}};
    req_i[RW +: RW] = {$urandom, $urandom, $urandom, $urandom};
    cache_req_ready_i = 1'b1;
    req_v_i = 2'b01;
    #1;
    n_cmp++; if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b exp 01", req_ready_o); end
    step();
    req_v_i = '0;
    req_metadata_i[0 +: MW] = 8'h5A; req_metadata_v_i = 2'b01;
    #1;
    n_cmp++; if (cache_req_v_o !== 1'b1) begin n_bad++; $display("FAIL single_v: got %b exp 1", cache_req_v_o); end
    n_cmp++; if (cache_req_o !== {16{8'hA5}}) begin n_bad++; $display("FAIL single_data: got %h exp a5..", cache_req_o); end
    step();
    req_metadata_v_i = '0;
    n_cmp++; if (cache_req_metadata_v_o !== 1'b1 || cache_req_metadata_o !== 8'h5A) begin n_bad++; $display("FAIL single_meta: got v%b %h exp v1 5a", cache_req_metadata_v_o, cache_req_metadata_o); end
    n_cmp++; if (cache_req_v_o !== 1'b0) begin n_bad++; $display("FAIL single_v_drop: got %b exp 0", cache_req_v_o); end
    step();
    n_cmp++; if (cache_req_metadata_v_o !== 1'b0) begin n_bad++; $display("FAIL single_meta_once: got %b exp 0", cache_req_metadata_v_o); end
    step(); step();
    cache_req_complete_i = 1'b1;
    step();
    cache_req_complete_i = 1'b0;
    n_cmp++; if (complete_o !== 2'b01 || busy_o !== 1'b0) begin n_bad++; $display("FAIL single_cpl: got %b busy %b exp 01 busy 0", complete_o, busy_o); end
    step();
    n_cmp++; if (complete_o !== 2'b00) begin n_bad++; $display("FAIL single_cpl_len: got %b exp 00", complete_o); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] oh;
    do_reset();
    req_v_i = 2'b11;
    cache_req_ready_i = 1'b1;
    for (int g = 0; g < 4; g++) begin
      oh = 2'b01 << (g % 2);
      cache_req_complete_i = 1'b0;
      #1;
      n_cmp++; if (req_ready_o !== oh) begin n_bad++; $display("FAIL rr_ready g=%0d: got %b exp %b", g, req_ready_o, oh); end
      if (g > 0) begin
        n_cmp++; if (complete_o !== (2'b01 << ((g - 1) % 2))) begin n_bad++; $display("FAIL rr_cpl g=%0d: got %b exp other", g, complete_o); end
      end
      step();
      req_metadata_i = {8'(g + 8'h10), 8'(g)};
      req_metadata_v_i = oh;
      #1;
      n_cmp++; if (grant_id_o !== 1'((g % 2))) begin n_bad++; $display("FAIL rr_gid g=%0d: got %0d exp %0d", g, grant_id_o, g % 2); end
      step();
      req_metadata_v_i = '0;
      n_cmp++; if (cache_req_metadata_v_o !== 1'b1) begin n_bad++; $display("FAIL rr_meta g=%0d: got %b exp 1", g, cache_req_metadata_v_o); end
      step();
      cache_req_complete_i = 1'b1;
      step();
    end
    cache_req_complete_i = 1'b0;
    n_cmp++; if (complete_o !== 2'b10) begin n_bad++; $display("FAIL rr_last_cpl: got %b exp 10", complete_o); end
    req_v_i = '0;
    step();
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] d;
    do_reset();
    d = {$urandom, $urandom, $urandom, $urandom};
    req_i[RW +: RW] = d;
    req_v_i = 2'b10;
    #1;
    n_cmp++; if (req_ready_o !== 2'b10) begin n_bad++; $display("FAIL bp_ready: got %b exp 10", req_ready_o); end
    step();
    for (int k = 0; k < 4; k++) begin
      req_v_i = 2'b11;
      req_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      req_metadata_i[MW +: MW] = 8'h42;
      req_metadata_v_i = (k == 1) ? 2'b10 : 2'b00;
      #1;
      n_cmp++; if (cache_req_v_o !== 1'b1 || cache_req_o !== d) begin n_bad++; $display("FAIL bp_hold k=%0d: got v%b %h exp v1 %h", k, cache_req_v_o, cache_req_o, d); end
      n_cmp++; if (req_ready_o !== 2'b00) begin n_bad++; $display("FAIL bp_ready_zero k=%0d: got %b exp 00", k, req_ready_o); end
      n_cmp++; if (cache_req_metadata_v_o !== 1'b0) begin n_bad++; $display("FAIL bp_no_meta k=%0d: got %b exp 0", k, cache_req_metadata_v_o); end
      step();
    end
    req_metadata_v_i = '0;
    cache_req_ready_i = 1'b1;
    #1;
    n_cmp++; if (cache_req_v_o !== 1'b1 || cache_req_o !== d || grant_id_o !== 1'b1) begin n_bad++; $display("FAIL bp_hs: got v%b gid %0d exp v1 gid 1", cache_req_v_o, grant_id_o); end
    step();
    req_v_i = '0;
    cache_req_ready_i = 1'b0;
    n_cmp++; if (cache_req_metadata_v_o !== 1'b1 || cache_req_metadata_o !== 8'h42) begin n_bad++; $display("FAIL bp_meta: got v%b %h exp v1 42", cache_req_metadata_v_o, cache_req_metadata_o); end
    step();
    cache_req_complete_i = 1'b1;
    step();
    cache_req_complete_i = 1'b0;
    n_cmp++; if (complete_o !== 2'b10) begin n_bad++; $display("FAIL bp_cpl: got %b exp 10", complete_o); end
  endtask

  task automatic test_late_meta();
    do_reset();
    req_v_i = 2'b01;
    cache_req_ready_i = 1'b1;
    step();
    req_v_i = '0;
    step();
    cache_req_ready_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      req_metadata_i = {8'hFF, 8'h3C};
      req_metadata_v_i = (k == 3) ? 2'b11 : 2'b10;
      #1;
      n_cmp++; if (cache_req_metadata_v_o !== 1'b0 || cache_req_metadata_o !== 8'h00) begin n_bad++; $display("FAIL late_wait k=%0d: got v%b %h exp v0 00", k, cache_req_metadata_v_o, cache_req_metadata_o); end
      step();
    end
    req_metadata_v_i = 2'b10;
    #1;
    n_cmp++; if (cache_req_metadata_v_o !== 1'b1 || cache_req_metadata_o !== 8'h3C) begin n_bad++; $display("FAIL late_emit: got v%b %h exp v1 3c", cache_req_metadata_v_o, cache_req_metadata_o); end
    step();
    req_metadata_v_i = '0;
    n_cmp++; if (cache_req_metadata_o !== 8'h3C || busy_o !== 1'b1) begin n_bad++; $display("FAIL late_stable: got %h busy %b exp 3c busy 1", cache_req_metadata_o, busy_o); end
    cache_req_complete_i = 1'b1;
    step();
    cache_req_complete_i = 1'b0;
    n_cmp++; if (complete_o !== 2'b01) begin n_bad++; $display("FAIL late_cpl: got %b exp 01", complete_o); end
  endtask

  task automatic test_spurious_cpl();
    do_reset();
    req_v_i = 2'b01;
    step();
    req_v_i = '0;
    for (int k = 0; k < 2; k++) begin
      cache_req_complete_i = 1'b1;
      cache_req_ready_i = (k == 1);
      #1;
      n_cmp++; if (cache_req_v_o !== 1'b1 || busy_o !== 1'b1 || complete_o !== 2'b00) begin n_bad++; $display("FAIL spur_send k=%0d: got v%b busy %b cpl %b exp v1 busy1 cpl00", k, cache_req_v_o, busy_o, complete_o); end
      step();
    end
    cache_req_ready_i = 1'b0;
    n_cmp++; if (complete_o !== 2'b00 || cache_req_metadata_v_o !== 1'b0 || busy_o !== 1'b1) begin n_bad++; $display("FAIL spur_meta0: got cpl %b mv %b busy %b exp 00 0 1", complete_o, cache_req_metadata_v_o, busy_o); end
    step();
    cache_req_complete_i = 1'b0;
    req_metadata_i[0 +: MW] = 8'h77; req_metadata_v_i = 2'b01;
    #1;
    n_cmp++; if (complete_o !== 2'b00 || busy_o !== 1'b1) begin n_bad++; $display("FAIL spur_meta1: got cpl %b busy %b exp 00 1", complete_o, busy_o); end
    step();
    req_metadata_v_i = '0;
    n_cmp++; if (cache_req_metadata_v_o !== 1'b1 || cache_req_metadata_o !== 8'h77) begin n_bad++; $display("FAIL simul_emit: got v%b %h exp v1 77", cache_req_metadata_v_o, cache_req_metadata_o); end
    cache_req_complete_i = 1'b1;
    step();
    cache_req_complete_i = 1'b0;
    n_cmp++; if (complete_o !== 2'b01 || busy_o !== 1'b0) begin n_bad++; $display("FAIL simul_cpl: got %b busy %b exp 01 busy 0", complete_o, busy_o); end
    step();
    n_cmp++; if (complete_o !== 2'b00) begin n_bad++; $display("FAIL simul_cpl_len: got %b exp 00", complete_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_i[RW +: RW] = {$urandom | 32'h1, $urandom, $urandom, $urandom};
    req_v_i = 2'b10;
    cache_req_ready_i = 1'b1;
    step();
    req_v_i = '0;
    req_metadata_i[MW +: MW] = 8'h99; req_metadata_v_i = 2'b10;
    step();
    req_metadata_v_i = '0;
    step();
    req_v_i = 2'b11;
    n_cmp++; if (busy_o !== 1'b1 || grant_id_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got busy %b gid %0d exp 1 1", busy_o, grant_id_o); end
    #1;
    reset_n_i = 1'b0;
    #1;
    n_cmp++; if (req_ready_o !== 2'b00 || complete_o !== 2'b00) begin n_bad++; $display("FAIL rstmid_hs: got rdy %b cpl %b exp 00 00", req_ready_o, complete_o); end
    n_cmp++; if (cache_req_o !== '0 || cache_req_v_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_req: got v%b %h exp v0 0", cache_req_v_o, cache_req_o); end
    n_cmp++; if (cache_req_metadata_o !== '0 || cache_req_metadata_v_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_meta: got v%b %h exp v0 0", cache_req_metadata_v_o, cache_req_metadata_o); end
    n_cmp++; if (busy_o !== 1'b0 || grant_id_o !== '0) begin n_bad++; $display("FAIL rstmid_state: got busy %b gid %0d exp 0 0", busy_o, grant_id_o); end
    reset_n_i = 1'b1;
    #1;
    n_cmp++; if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL rstmid_prio: got %b exp 01", req_ready_o); end
    step();
    n_cmp++; if (grant_id_o !== 1'b0 || cache_req_v_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_grant: got gid %0d v%b exp 0 v1", grant_id_o, cache_req_v_o); end
  endtask

  // One randomized transaction, starting in an IDLE cycle; m_last holds the model's last owner.
  task automatic random_txn(input int t);
    logic [N-1:0]  v, oh, exp_rdy;
    logic [RW-1:0] data [N];
    logic [RW-1:0] exp_data;
    logic [MW-1:0] om_val [16];
    logic [MW-1:0] exp_meta;
    bit om [16];
    bit nm [16];
    bit spur [16];
    int w, h, e, p, last_c, n_early, n_idle;
    v = N'($urandom_range(1, (1 << N) - 1));
    w = -1;
    for (int k = 1; k <= N; k++) if (w < 0 && v[(m_last + k) % N]) w = (m_last + k) % N;
    oh = '0; oh[w] = 1'b1;
    for (int i = 0; i < N; i++) data[i] = {$urandom, $urandom, $urandom, $urandom};
    exp_data = data[w];
    h = 1 + $urandom_range(0, 3);
    for (int c = 0; c < 16; c++) begin
      om[c] = 1'b0; spur[c] = 1'b0;
      nm[c] = ($urandom_range(0, 2) == 0);
      om_val[c] = 8'($urandom);
    end
    n_early = $urandom_range(0, 2);
    for (int j = 0; j < n_early; j++) om[$urandom_range(1, h)] = 1'b1;
    e = 0; exp_meta = '0;
    for (int c = 1; c <= h; c++) if (om[c]) begin exp_meta = om_val[c]; e = h + 1; end
    if (e == 0) begin
      p = h + 1 + $urandom_range(0, 3);
      om[p] = 1'b1; exp_meta = om_val[p]; e = p + 1;
    end
    for (int c = 1; c < e; c++) spur[c] = ($urandom_range(0, 3) == 0);
    last_c = e + $urandom_range(0, 3);
    for (int c = 0; c <= last_c; c++) begin
      req_v_i = (c == 0) ? v : N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_i[i*RW +: RW] = (c == 0) ? data[i] : {$urandom, $urandom, $urandom, $urandom};
        req_metadata_i[i*MW +: MW] = 8'($urandom);
      end
      if (om[c]) req_metadata_i[w*MW +: MW] = om_val[c];
      req_metadata_v_i = (nm[c] ? (N'($urandom) & ~oh) : '0) | (om[c] ? oh : '0);
      cache_req_ready_i = (c == h) ? 1'b1 : (c > 0 && c < h) ? 1'b0 : 1'($urandom);
      cache_req_complete_i = (c == last_c) | spur[c];
      #1;
      exp_rdy = (c == 0) ? oh : '0;
      n_cmp++; if (req_ready_o !== exp_rdy) begin n_bad++; $display("FAIL rnd_ready t=%0d c=%0d: got %b exp %b", t, c, req_ready_o, exp_rdy); end
      n_cmp++; if (busy_o !== (c != 0)) begin n_bad++; $display("FAIL rnd_busy t=%0d c=%0d: got %b exp %b", t, c, busy_o, c != 0); end
      n_cmp++; if (cache_req_v_o !== (c >= 1 && c <= h)) begin n_bad++; $display("FAIL rnd_v t=%0d c=%0d: got %b", t, c, cache_req_v_o); end
      n_cmp++; if (cache_req_metadata_v_o !== (c == e)) begin n_bad++; $display("FAIL rnd_meta_v t=%0d c=%0d: got %b exp %b", t, c, cache_req_metadata_v_o, c == e); end
      if (c >= 1) begin
        n_cmp++; if (cache_req_o !== exp_data || grant_id_o !== 1'(w)) begin n_bad++; $display("FAIL rnd_req t=%0d c=%0d: got gid %0d %h exp gid %0d %h", t, c, grant_id_o, cache_req_o, w, exp_data); end
        n_cmp++; if (complete_o !== '0) begin n_bad++; $display("FAIL rnd_early_cpl t=%0d c=%0d: got %b exp 0", t, c, complete_o); end
      end
      if (c == e) begin
        n_cmp++; if (cache_req_metadata_o !== exp_meta) begin n_bad++; $display("FAIL rnd_meta t=%0d: got %h exp %h", t, cache_req_metadata_o, exp_meta); end
      end
      step();
    end
    m_last = w;
    cache_req_complete_i = 1'b0;
    n_cmp++; if (complete_o !== oh || busy_o !== 1'b0) begin n_bad++; $display("FAIL rnd_cpl t=%0d: got %b busy %b exp %b busy 0", t, complete_o, busy_o, oh); end
    n_idle = $urandom_range(0, 2);
    for (int k = 0; k < n_idle; k++) begin
      req_v_i = '0;
      req_metadata_v_i = N'($urandom);
      cache_req_ready_i = 1'($urandom);
      #1;
      n_cmp++; if (req_ready_o !== '0) begin n_bad++; $display("FAIL rnd_idle_ready t=%0d: got %b exp 0", t, req_ready_o); end
      step();
      n_cmp++; if (complete_o !== '0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL rnd_idle t=%0d: got cpl %b busy %b exp 0 0", t, complete_o, busy_o); end
    end
  endtask

  task automatic test_random();
    do_reset();
    m_last = N - 1;
    for (int t = 0; t < 60; t++) random_txn(t);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; m_last = N - 1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_late_meta();
    test_spurious_cpl();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
